mc_mem_fill: RTL and testbench

- Multi-channel, parametrised successor of the single-channel UDP packet buffer filler.
- Accepts CH_NUM sample streams, already synchronous to clk. Each channel has its own skid FIFO; a round-robin arbiter feeds them into a ping-pong pair of dual-port RAMs addressed by {channel, sample counter}.
- Banks swap on each main-sync falling edge. The packet builder reads the frozen bank through a 1-cycle read port, with per-channel overflow/range status.

---
 rtl/mc_mem_fill_pkg.sv | 21 ++
 rtl/mc_mem_fill_ch_fifo.sv | 51 +++++
 rtl/mc_mem_fill.sv | 185 ++++++++++++++++++
 tb/tb_mc_mem_fill.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mc_mem_fill_pkg.sv
// mc_mem_fill_pkg: shared FSM state type, frame-counter width and address-width helpers
// for the multi-channel ping-pong memory filler. No ports.
package mc_mem_fill_pkg;

    localparam int FCNT_W = 16;

    typedef enum logic {
        ST_FILL,
        ST_CLEAR
    } state_t;

    // A single channel still needs one channel-select bit so the address map stays uniform.
    function automatic int calc_ch_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int calc_addr_w(input int ch_num, input int smp_w);
        return calc_ch_w(ch_num) + smp_w;
    endfunction

endpackage

// File: rtl/mc_mem_fill_ch_fifo.sv
// mf_ch_fifo: per-channel synchronous skid FIFO with synchronous flush.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the FIFO; a push in the same cycle lands in the emptied FIFO
//   push, din   write request and data (ignored while full)
//   pop         read request (ignored while empty or flushing)
//   dout        head-of-FIFO data (show-ahead)
//   full, empty occupancy status
module mf_ch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wp, rp, wbase;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wbase   = flush ? '0 : wp;
    assign empty   = wp == rp;
    assign full    = wp == {~rp[PW], rp[PW-1:0]};
    assign do_push = push && (flush || !full);
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rp[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wbase + (PW+1)'(do_push);
            rp <= flush ? '0 : rp + (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wbase[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mc_mem_fill.sv
// mc_mem_fill: multi-channel sample collector into a ping-pong pair of frame banks.
// Each channel feeds a skid FIFO; a round-robin arbiter drains one sample per cycle
// into the write bank at {channel, sample index}. A falling edge on i_msync_n swaps
// banks, latches per-channel overflow/range status and bumps the frame counter.
// Optional build macro MC_MEM_FILL_BANK_CLEAR_EN: zero the new write bank after every
// swap (and after reset) before filling resumes.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_msync_n     active-low frame sync; its falling edge closes the current frame
//   i_ch_data     CH_NUM packed samples, channel k at [k*DATA_W +: DATA_W]
//   i_ch_vld      per-channel sample valid
//   i_ch_cntr     CH_NUM packed sample indices, channel k at [k*CNTR_W +: CNTR_W]
//   i_rd_addr     {channel, sample} read address into the readable bank
//   o_rd_data     registered read data (1-cycle latency)
//   o_bank        readable bank index
//   o_frame_rdy   one-cycle pulse after a bank swap
//   o_ovf, o_rng  per-channel FIFO-overflow / index-out-of-range flags of the last frame
//   o_frame_cnt   completed frame count (wrapping)
module mc_mem_fill
    import mc_mem_fill_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DATA_W     = 32,
    parameter int CNTR_W     = 10,
    parameter int SMP_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_msync_n,
    input  logic [CH_NUM*DATA_W-1:0]             i_ch_data,
    input  logic [CH_NUM-1:0]                    i_ch_vld,
    input  logic [CH_NUM*CNTR_W-1:0]             i_ch_cntr,
    input  logic [calc_addr_w(CH_NUM, SMP_W)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]                    o_rd_data,
    output logic                                 o_bank,
    output logic                                 o_frame_rdy,
    output logic [CH_NUM-1:0]                    o_ovf,
    output logic [CH_NUM-1:0]                    o_rng,
    output logic [FCNT_W-1:0]                    o_frame_cnt
);
    localparam int CH_W   = calc_ch_w(CH_NUM);
    localparam int ADDR_W = CH_W + SMP_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FW     = SMP_W + DATA_W;

    logic              ms_q, msync, wr_bank, stall;
    state_t            state, state_nxt;
    logic [CH_NUM-1:0] push, pop, full, empty, rng_set, ovf_set;
    logic [CH_NUM-1:0] work_ovf, work_rng;
    logic [FW-1:0]     f_dout [CH_NUM];
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch, rr_ptr;
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];
`ifdef MC_MEM_FILL_BANK_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
    logic [ADDR_W-1:0] clr_addr;
`else
    localparam state_t RST_STATE = ST_FILL;
`endif

    // Edge detect against the registered copy so msync is valid in the cycle the
    // falling input is first seen.
    assign msync = ms_q & ~i_msync_n;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [CNTR_W-1:0] cntr;
        assign cntr       = i_ch_cntr[k*CNTR_W +: CNTR_W];
        assign rng_set[k] = i_ch_vld[k] && ((cntr >> SMP_W) != '0);
        assign push[k]    = i_ch_vld[k] && !rng_set[k];
        // The msync-cycle sample goes into a freshly flushed FIFO and cannot overflow.
        assign ovf_set[k] = push[k] && full[k] && !msync;
        assign pop[k]     = gnt_vld && (gnt_ch == CH_W'(k));
        mf_ch_fifo #(
            .W    (FW),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .flush(msync),
            .push (push[k]),
            .din  ({cntr[SMP_W-1:0], i_ch_data[k*DATA_W +: DATA_W]}),
            .pop  (pop[k]),
            .dout (f_dout[k]),
            .full (full[k]),
            .empty(empty[k])
        );
    end

    // rr_ptr holds the first channel to consider, i.e. last grant + 1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!stall && !gnt_vld && !empty[(int'(rr_ptr) + i) % CH_NUM]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CH_W'((int'(rr_ptr) + i) % CH_NUM);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = msync;
        ram_we    = wr_vld;
        ram_addr  = wr_addr;
        ram_din   = wr_data;
`ifdef MC_MEM_FILL_BANK_CLEAR_EN
        if (state == ST_CLEAR) begin
            stall     = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_din   = '0;
            state_nxt = (&clr_addr) ? ST_FILL : ST_CLEAR;
        end
        if (msync) state_nxt = ST_CLEAR;
`endif
    end

`ifdef MC_MEM_FILL_BANK_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 clr_addr <= '0;
        else if (msync)             clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q        <= 1'b1;
            wr_bank     <= 1'b0;
            o_bank      <= 1'b1;
            o_frame_rdy <= 1'b0;
            o_ovf       <= '0;
            o_rng       <= '0;
            o_frame_cnt <= '0;
            work_ovf    <= '0;
            work_rng    <= '0;
            rr_ptr      <= '0;
            wr_vld      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            o_rd_data   <= '0;
        end else begin
            ms_q        <= i_msync_n;
            o_frame_rdy <= msync;
            wr_vld      <= gnt_vld;
            if (gnt_vld) begin
                rr_ptr  <= (gnt_ch == CH_W'(CH_NUM - 1)) ? '0 : gnt_ch + CH_W'(1);
                wr_addr <= {gnt_ch, f_dout[gnt_ch][FW-1:DATA_W]};
                wr_data <= f_dout[gnt_ch][DATA_W-1:0];
            end
            // Flags raised in the msync cycle already belong to the new frame.
            work_ovf <= (msync ? '0 : work_ovf) | ovf_set;
            work_rng <= (msync ? '0 : work_rng) | rng_set;
            if (msync) begin
                wr_bank     <= ~wr_bank;
                o_bank      <= wr_bank;
                o_ovf       <= work_ovf;
                o_rng       <= work_rng;
                o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
            end
            o_rd_data <= o_bank ? bank1[i_rd_addr] : bank0[i_rd_addr];
        end
    end

    // A write still in the register stage at msync uses the pre-swap wr_bank.
    always_ff @(posedge clk) begin
        if (ram_we && !wr_bank) bank0[ram_addr] <= ram_din;
        if (ram_we && wr_bank)  bank1[ram_addr] <= ram_din;
    end

endmodule

// File: tb/tb_mc_mem_fill.sv
// tb_mc_mem_fill: directed self-checking bench for mc_mem_fill (default parameters).
`timescale 1ns/1ps
module tb_mc_mem_fill;
    import mc_mem_fill_pkg::*;

    localparam int CH_NUM = 4, DATA_W = 32, CNTR_W = 10, SMP_W = 8, FIFO_DEPTH = 4;
`ifdef MC_MEM_FILL_BANK_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       i_msync_n = 1'b1;
    logic [CH_NUM*DATA_W-1:0]   i_ch_data = '0;
    logic [CH_NUM-1:0]          i_ch_vld = '0;
    logic [CH_NUM*CNTR_W-1:0]   i_ch_cntr = '0;
    logic [9:0]                 i_rd_addr = '0;
    logic [DATA_W-1:0]          o_rd_data;
    logic                       o_bank, o_frame_rdy;
    logic [CH_NUM-1:0]          o_ovf, o_rng;
    logic [15:0]                o_frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        int          cntr;
        logic [31:0] data;
        bit          wr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    mc_mem_fill #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .CNTR_W(CNTR_W), .SMP_W(SMP_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_msync_n(i_msync_n), .i_ch_data(i_ch_data),
        .i_ch_vld(i_ch_vld), .i_ch_cntr(i_ch_cntr), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_bank(o_bank), .o_frame_rdy(o_frame_rdy),
        .o_ovf(o_ovf), .o_rng(o_rng), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the post-swap bank clear finish when that feature is built in.
    task automatic settle();
        if (CLR) repeat (1030) tick();
    endtask

    task automatic set_ch(input int ch, input int cntr, input logic [31:0] data);
        i_ch_vld[ch]                  = 1'b1;
        i_ch_cntr[ch*CNTR_W +: CNTR_W] = CNTR_W'(cntr);
        i_ch_data[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic send(input int ch, input int cntr, input logic [31:0] data);
        set_ch(ch, cntr, data);
        tick();
        i_ch_vld = '0;
    endtask

    task automatic do_msync(input logic exp_bank, input int exp_cnt, input logic [3:0] exp_ovf,
                            input logic [3:0] exp_rng);
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
        check("frame_rdy", 32'(o_frame_rdy), 32'd1);
        check("bank", 32'(o_bank), 32'(exp_bank));
        check("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
        check("ovf", 32'(o_ovf), 32'(exp_ovf));
        check("rng", 32'(o_rng), 32'(exp_rng));
        tick();
        check("frame_rdy_end", 32'(o_frame_rdy), 32'd0);
    endtask

    task automatic rd(input string name, input int ch, input int smp, input logic [31:0] exp);
        i_rd_addr = {2'(ch), 8'(smp)};
        tick();
        check(name, o_rd_data, exp);
    endtask

    initial begin
        tbl[0] = '{1, 3,   32'h11110003, 1'b1, 32'h11110BAD};
        tbl[1] = '{2, 255, 32'h222200FF, 1'b1, 32'h222200FF};
        tbl[2] = '{3, 0,   32'h33330000, 1'b1, 32'h33330000};
        tbl[3] = '{1, 44,  32'h1111002C, 1'b1, 32'h1111002C};
        tbl[4] = '{1, 300, 32'hDEAD012C, 1'b0, 32'h0};
        tbl[5] = '{3, 256, 32'hDEAD0100, 1'b0, 32'h0};
        tbl[6] = '{0, 10,  32'h0A0A000A, 1'b1, 32'h0A0A000A};
        tbl[7] = '{1, 3,   32'h11110BAD, 1'b1, 32'h11110BAD};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", o_rd_data, 32'h0);
        check("rst_bank", 32'(o_bank), 32'd1);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        check("rst_frame_rdy", 32'(o_frame_rdy), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_rng", 32'(o_rng), 32'd0);
        rst_n = 1'b1;
        tick();
        settle();

        // Frame 1: ch0 fills all 256 samples of bank 0.
        for (int n = 0; n < 256; n++) send(0, n, 32'hA5A50000 + 32'(n));
        repeat (4) tick();
        do_msync(1'b0, 1, 4'h0, 4'h0);
        for (int n = 0; n < 256; n++) rd("fill_ch0", 0, n, 32'hA5A50000 + 32'(n));
        settle();

        // Frame 2: table vectors into bank 1, with duplicates and out-of-range indices.
        for (int i = 0; i < 8; i++) send(tbl[i].ch, tbl[i].cntr, tbl[i].data);
        repeat (4) tick();
        do_msync(1'b1, 2, 4'h0, 4'b1010);
        for (int i = 0; i < 8; i++)
            if (tbl[i].wr) rd("tbl", tbl[i].ch, tbl[i].cntr & 255, tbl[i].exp);
        settle();

        // Frame 3: all channels valid in one cycle; the last write lands in the msync cycle.
        for (int k = 0; k < 4; k++) set_ch(k, 7, 32'h51000000 + 32'(k));
        tick();
        i_ch_vld = '0;
        repeat (4) tick();
        do_msync(1'b0, 3, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) rd("burst", k, 7, 32'h51000000 + 32'(k));
        rd("stale", 0, 8, CLR ? 32'h0 : 32'hA5A50008);
        settle();

        // Frame 4: four channels streaming every cycle exceed the drain rate.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) set_ch(k, 100 + i, 32'hF0000000 + 32'(k * 16 + i));
            tick();
        end
        i_ch_vld = '0;
        repeat (20) tick();
        do_msync(1'b1, 4, 4'hF, 4'h0);
        settle();

        // Frame 5: quiet; a read issued in the msync cycle still sees the old bank.
        i_rd_addr = {2'd1, 8'd3};
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
        check("rd_in_msync", o_rd_data, CLR ? 32'h0 : 32'h11110BAD);
        check("q_bank", 32'(o_bank), 32'd0);
        check("q_frame_cnt", 32'(o_frame_cnt), 32'd5);
        check("q_ovf", 32'(o_ovf), 32'd0);
        check("q_rng", 32'(o_rng), 32'd0);
        rd("after_swap", 0, 7, CLR ? 32'h0 : 32'h51000000);
        rd("stale2", 0, 20, CLR ? 32'h0 : 32'hA5A50014);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
